ex_mem_flag_stage: RTL and testbench

- Registered stage directly downstream of the 16-bit ALU.
- Captures ALU_Out, Error and the {Z,V,N} flags into the EX/MEM pipeline register.
- Holds the architectural flag register, updated with a per-opcode mask.
- Resolves branch conditions for the ID stage using bypassed flags, and keeps a saturating overflow event counter for debug.

---
 rtl/ex_mem_flag_stage_if.sv | 41 ++++
 rtl/ex_mem_flag_stage.sv | 100 ++++++++++
 tb/tb_ex_mem_flag_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_flag_stage_if.sv
// EX -> MEM flag stage bus: ALU results in, pipeline register and branch outcome out.
// master drives EX/ID side, slave is the stage itself.
interface ex_mem_flag_if #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int OVF_CNT_W = 8
);
    logic                 ex_valid;
    logic [3:0]           ex_opcode;
    logic [DATA_W-1:0]    alu_out;
    logic [2:0]           alu_flags;
    logic                 alu_error;
    logic [REG_AW-1:0]    ex_rd;
    logic                 ex_regwrite;
    logic                 stall;
    logic                 flush;
    logic                 br_valid;
    logic [2:0]           br_cond;
    logic                 mem_valid;
    logic [DATA_W-1:0]    mem_alu_out;
    logic [REG_AW-1:0]    mem_rd;
    logic                 mem_regwrite;
    logic                 mem_error;
    logic [2:0]           flags;
    logic                 br_taken;
    logic [OVF_CNT_W-1:0] ovf_count;

    modport master (
        output ex_valid, ex_opcode, alu_out, alu_flags, alu_error,
        output ex_rd, ex_regwrite, stall, flush, br_valid, br_cond,
        input  mem_valid, mem_alu_out, mem_rd, mem_regwrite, mem_error,
        input  flags, br_taken, ovf_count
    );

    modport slave (
        input  ex_valid, ex_opcode, alu_out, alu_flags, alu_error,
        input  ex_rd, ex_regwrite, stall, flush, br_valid, br_cond,
        output mem_valid, mem_alu_out, mem_rd, mem_regwrite, mem_error,
        output flags, br_taken, ovf_count
    );
endinterface

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with masked {Z,V,N} flag register,
// bypassed branch resolution and saturating overflow counter.
module ex_mem_flag_stage #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_mem_flag_if.slave    bus
);
    logic                 r_valid;
    logic [DATA_W-1:0]    r_alu_out;
    logic [REG_AW-1:0]    r_rd;
    logic                 r_regwrite;
    logic                 r_error;
    logic [2:0]           r_flags;
    logic [OVF_CNT_W-1:0] r_ovf;

    logic       w_advance;
    logic       w_flag_wr;
    logic       w_ovf_inc;
    logic [2:0] w_mask;
    logic [2:0] w_eff;
    logic       w_cond;

    assign w_advance = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign w_flag_wr = w_advance & ~bus.ex_opcode[3];
    assign w_ovf_inc = w_flag_wr & (bus.ex_opcode[2:1] == 2'b00)
                     & bus.alu_error;

    always_comb begin
        w_mask = 3'b000;
        case (bus.ex_opcode[2:0])
            3'b000, 3'b001:                 w_mask = 3'b111;
            3'b010, 3'b100, 3'b101, 3'b110: w_mask = 3'b100;
            default:                        w_mask = 3'b000;
        endcase
    end

    // New flags are visible to the branch in ID in the same cycle
    assign w_eff = w_flag_wr
                 ? ((bus.alu_flags & w_mask) | (r_flags & ~w_mask))
                 : r_flags;

    always_comb begin
        w_cond = 1'b0;
        case (bus.br_cond)
            3'b000:  w_cond = ~w_eff[2];
            3'b001:  w_cond = w_eff[2];
            3'b010:  w_cond = ~w_eff[2] & ~w_eff[0];
            3'b011:  w_cond = w_eff[0];
            3'b100:  w_cond = w_eff[2] | (~w_eff[2] & ~w_eff[0]);
            3'b101:  w_cond = w_eff[0] | w_eff[2];
            3'b110:  w_cond = w_eff[1];
            default: w_cond = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_alu_out  <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_error    <= 1'b0;
        end else if (bus.flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_error    <= 1'b0;
        end else if (!bus.stall) begin
            r_valid    <= bus.ex_valid;
            r_alu_out  <= bus.alu_out;
            r_rd       <= bus.ex_rd;
            r_regwrite <= bus.ex_regwrite & bus.ex_valid;
            r_error    <= bus.alu_error & bus.ex_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 3'b000;
            r_ovf   <= '0;
        end else begin
            if (w_flag_wr)
                r_flags <= w_eff;
            if (w_ovf_inc && (r_ovf != '1))
                r_ovf <= r_ovf + 1'b1;
        end
    end

    assign bus.mem_valid    = r_valid;
    assign bus.mem_alu_out  = r_alu_out;
    assign bus.mem_rd       = r_rd;
    assign bus.mem_regwrite = r_regwrite;
    assign bus.mem_error    = r_error;
    assign bus.flags        = r_flags;
    assign bus.ovf_count    = r_ovf;
    assign bus.br_taken     = bus.br_valid & w_cond;
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Scoreboard bench for ex_mem_flag_stage: directed plan plus random traffic
// against a flag-rule reference model.
module tb_ex_mem_flag_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_mem_flag_if bus ();
    ex_mem_flag_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        valid;
        logic [15:0] alu;
        logic [3:0]  rd;
        logic        rw;
        logic        err;
        logic [2:0]  flags;
        logic [7:0]  ovf;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   checks = 0;
    int   fails  = 0;

    // Which flags an opcode architecturally writes, by instruction name
    function automatic logic [2:0] apply(input logic [3:0] op,
                                         input logic [2:0] nf,
                                         input logic [2:0] old);
        if (op == 4'd0 || op == 4'd1) return nf;
        if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) return {nf[2], old[1:0]};
        return old;
    endfunction

    function automatic logic cond(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m.valid = 0; m.alu = 0; m.rd = 0; m.rw = 0;
        m.err = 0; m.flags = 0; m.ovf = 0;
    endtask

    task automatic step(input logic v, input logic [3:0] op,
                        input logic [15:0] a, input logic [2:0] f,
                        input logic e, input logic [3:0] rd,
                        input logic rw, input logic st, input logic fl,
                        input logic bv, input logic [2:0] bc);
        logic [2:0] eff;
        logic       adv;
        logic       exp_br;
        @(negedge clk);
        bus.ex_valid = v;   bus.ex_opcode = op; bus.alu_out = a;
        bus.alu_flags = f;  bus.alu_error = e;  bus.ex_rd = rd;
        bus.ex_regwrite = rw; bus.stall = st;   bus.flush = fl;
        bus.br_valid = bv;  bus.br_cond = bc;
        adv = v && !st && !fl;
        eff = adv ? apply(op, f, m.flags) : m.flags;
        exp_br = bv && cond(bc, eff);
        #1;
        checks++;
        if (bus.br_taken !== exp_br) begin
            fails++;
            $display("FAIL br_taken cond=%0d flags=%b: got %b want %b",
                     bc, eff, bus.br_taken, exp_br);
        end
        if (fl) begin
            m.valid = 0; m.rw = 0; m.err = 0;
        end else if (!st) begin
            m.valid = v; m.alu = a; m.rd = rd;
            m.rw = rw && v; m.err = e && v;
        end
        m.flags = eff;
        if (adv && op <= 4'd1 && e && m.ovf < 8'd255) m.ovf = m.ovf + 8'd1;
        q.push_back(m);
    endtask

    task automatic idle_br(input logic bv, input logic [2:0] bc);
        step(0, 4'd8, 16'h0, 3'b000, 0, 4'd0, 0, 0, 0, bv, bc);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.mem_valid !== 0 || bus.mem_alu_out !== 0 || bus.mem_rd !== 0 ||
            bus.mem_regwrite !== 0 || bus.mem_error !== 0 ||
            bus.flags !== 0 || bus.ovf_count !== 0) begin
            fails++;
            $display("FAIL %s: got v=%b alu=%h rd=%h rw=%b err=%b fl=%b ovf=%0d want all 0",
                     tag, bus.mem_valid, bus.mem_alu_out, bus.mem_rd,
                     bus.mem_regwrite, bus.mem_error, bus.flags, bus.ovf_count);
        end
    endtask

    // Monitor: compares the registered state right after each edge
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (bus.mem_valid !== x.valid || bus.mem_alu_out !== x.alu ||
                bus.mem_rd !== x.rd || bus.mem_regwrite !== x.rw ||
                bus.mem_error !== x.err || bus.flags !== x.flags ||
                bus.ovf_count !== x.ovf) begin
                fails++;
                $display("FAIL mem_state: got v=%b alu=%h rd=%h rw=%b err=%b fl=%b ovf=%0d want v=%b alu=%h rd=%h rw=%b err=%b fl=%b ovf=%0d",
                         bus.mem_valid, bus.mem_alu_out, bus.mem_rd,
                         bus.mem_regwrite, bus.mem_error, bus.flags,
                         bus.ovf_count, x.valid, x.alu, x.rd, x.rw,
                         x.err, x.flags, x.ovf);
            end
        end
    end

    initial begin
        bus.ex_valid = 0; bus.ex_opcode = 0; bus.alu_out = 0;
        bus.alu_flags = 0; bus.alu_error = 0; bus.ex_rd = 0;
        bus.ex_regwrite = 0; bus.stall = 0; bus.flush = 0;
        bus.br_valid = 0; bus.br_cond = 0;
        model_reset();
        #1;
        check_reset_outputs("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD then XOR with same-cycle bypass
        step(1, 4'd0, 16'h1111, 3'b011, 0, 4'd1, 1, 0, 0, 0, 3'd0);
        step(1, 4'd2, 16'h2222, 3'b100, 0, 4'd2, 1, 0, 0, 1, 3'd1);
        // ADD to flags=010, then RED/PADSUB/non-ALU leave flags alone
        step(1, 4'd0, 16'h0003, 3'b010, 0, 4'd3, 1, 0, 0, 0, 3'd0);
        step(1, 4'd3, 16'hAAAA, 3'b111, 0, 4'd4, 1, 0, 0, 1, 3'd6);
        step(1, 4'd7, 16'hBBBB, 3'b111, 0, 4'd5, 0, 0, 0, 1, 3'd1);
        step(1, 4'd8, 16'hCCCC, 3'b111, 1, 4'd6, 1, 0, 0, 1, 3'd3);
        // Stall holds everything, branch sees old flags
        step(1, 4'd0, 16'h1234, 3'b101, 1, 4'd7, 1, 1, 0, 1, 3'd1);
        // Flush beats stall
        step(1, 4'd0, 16'h5678, 3'b111, 1, 4'd8, 1, 1, 1, 1, 3'd6);
        step(0, 4'd0, 16'h9999, 3'b111, 1, 4'd9, 1, 0, 0, 1, 3'd2);

        // Branch matrix with no bypass
        for (int f = 0; f < 8; f++) begin
            step(1, 4'd0, 16'(f), 3'(f), 0, 4'd0, 0, 0, 0, 0, 3'd0);
            for (int c = 0; c < 8; c++) idle_br(1, 3'(c));
            idle_br(0, 3'd7);
        end

        // Saturating overflow counter
        for (int i = 0; i < 260; i++)
            step(1, 4'd1, 16'(i), 3'b010, 1, 4'd1, 1, 0, 0, 0, 3'd0);
        step(1, 4'd2, 16'h0, 3'b000, 1, 4'd1, 1, 0, 0, 0, 3'd0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 8, 4'($urandom), 16'($urandom),
                 3'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
                 1'($urandom), 3'($urandom));

        // Async reset mid-stream with mem_valid=1 and flags=111
        step(1, 4'd0, 16'hFFFF, 3'b111, 0, 4'd15, 1, 0, 0, 0, 3'd0);
        @(posedge clk);
        #3;
        bus.ex_valid = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        idle_br(1, 3'd1);
        idle_br(1, 3'd0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
